// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared types and constants for the operand loader.
// Rev 1.0
`default_nettype none

package operand_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'b10101100;

  localparam int F_A        = 0;
  localparam int F_B        = 1;
  localparam int F_ENF      = 2;
  localparam int F_LOAD     = 3;
  localparam int F_QTD      = 4;
  localparam int F_BASE     = 5;
  localparam int NUM_FIELDS = 6;

  function automatic int bytes_per_field(input int bw);
    return (bw + 8) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_loader_field_assembler.sv
// field_assembler: byte-addressed shadow register for one operand field.
// Rev 1.0
`default_nettype none

module field_assembler
  import operand_loader_pkg::*;
#(
  parameter int bus_width = 32,
  localparam int BPF = bytes_per_field(bus_width),
  localparam int IW  = (BPF > 1) ? $clog2(BPF) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IW-1:0]        byte_idx,
  input  logic [7:0]           byte_data,
  input  logic                 wr_en,
  output logic [bus_width:0]   value
);

  logic [bus_width:0] r_shadow;

  // value is the shadow with the current byte already merged, so a set can
  // be loaded on the same edge that accepts its final byte.
  always_comb begin
    value = r_shadow;
    if (wr_en) begin
      for (int i = 0; i <= bus_width; i++) begin
        if (int'(byte_idx) == i / 8) value[i] = byte_data[i % 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_shadow <= '0;
    else     r_shadow <= value;
  end

endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// operand_loader: assembles sync-framed six-field operand sets from a byte stream.
// Rev 1.0
`default_nettype none

module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int         bus_width = 32,
  parameter logic [7:0] sync_byte = SYNC_BYTE_DEFAULT
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [7:0]         din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [bus_width:0] a,
  output logic [bus_width:0] b,
  output logic [bus_width:0] enf,
  output logic [bus_width:0] load,
  output logic [bus_width:0] qtd,
  output logic [bus_width:0] base,
  output logic               out_valid,
  input  logic               out_ack,
  output logic [7:0]         sync_err_cnt
);

  localparam int            BPF        = bytes_per_field(bus_width);
  localparam int            IW         = (BPF > 1) ? $clog2(BPF) : 1;
  localparam logic [IW-1:0] LAST_BYTE  = IW'(BPF - 1);
  localparam logic [2:0]    LAST_FIELD = 3'(F_BASE);

  state_t             r_state;
  logic [2:0]         r_field;
  logic [IW-1:0]      r_byte;
  logic [bus_width:0] r_ops    [NUM_FIELDS];
  logic [bus_width:0] w_shadow [NUM_FIELDS];

  logic w_xfer;
  logic w_last;
  logic w_free;
  logic w_load_fire;

  assign din_ready   = (r_state != PEND);
  assign w_xfer      = din_valid && din_ready;
  assign w_last      = (r_field == LAST_FIELD) && (r_byte == LAST_BYTE);
  assign w_free      = !out_valid || out_ack;
  assign w_load_fire = ((r_state == LOAD) && w_xfer && w_last && w_free) ||
                       ((r_state == PEND) && out_ack);

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
    field_assembler #(.bus_width(bus_width)) u_field (
      .clk       (sysclk),
      .rst       (reset),
      .byte_idx  (r_byte),
      .byte_data (din),
      .wr_en     (w_xfer && (r_state == LOAD) && (r_field == 3'(f))),
      .value     (w_shadow[f])
    );
  end

  assign a    = r_ops[F_A];
  assign b    = r_ops[F_B];
  assign enf  = r_ops[F_ENF];
  assign load = r_ops[F_LOAD];
  assign qtd  = r_ops[F_QTD];
  assign base = r_ops[F_BASE];

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_field      <= '0;
      r_byte       <= '0;
      out_valid    <= 1'b0;
      sync_err_cnt <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) r_ops[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (din == sync_byte) begin
              r_state <= LOAD;
              r_field <= '0;
              r_byte  <= '0;
            end else if (sync_err_cnt != 8'hFF) begin
              sync_err_cnt <= sync_err_cnt + 8'd1;
            end
          end
        end
        LOAD: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= w_free ? IDLE : PEND;
              r_field <= '0;
              r_byte  <= '0;
            end else if (r_byte == LAST_BYTE) begin
              r_byte  <= '0;
              r_field <= r_field + 3'd1;
            end else begin
              r_byte  <= r_byte + IW'(1);
            end
          end
        end
        PEND: begin
          if (out_ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // A new set replaces the held one atomically; a bare ack just releases it.
      if (w_load_fire) begin
        for (int i = 0; i < NUM_FIELDS; i++) r_ops[i] <= w_shadow[i];
        out_valid <= 1'b1;
      end else if (out_ack) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// tb_operand_loader: scoreboard bench for operand_loader with a frame-level reference model.
// Rev 1.0
`default_nettype none

module tb_operand_loader;

  localparam int         BW   = 32;
  localparam int         BPF  = (BW + 8) / 8;
  localparam logic [7:0] SYNC = 8'hAC;

  typedef logic [5:0][BW:0] set_t;
  typedef logic [5:0][39:0] raw_t;

  logic          sysclk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    din = 8'h00;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [BW:0]   a, b, enf, load, qtd, base;
  logic          out_valid;
  logic          out_ack = 1'b0;
  logic [7:0]    sync_err_cnt;

  int   checks = 0;
  int   passes = 0;
  set_t exp_q[$];
  int   exp_err = 0;
  bit   auto_ack = 1'b0;

  bit   prev_valid = 1'b0;
  bit   prev_acked = 1'b0;
  set_t prev_set;

  operand_loader #(.bus_width(BW), .sync_byte(SYNC)) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .a            (a),
    .b            (b),
    .enf          (enf),
    .load         (load),
    .qtd          (qtd),
    .base         (base),
    .out_valid    (out_valid),
    .out_ack      (out_ack),
    .sync_err_cnt (sync_err_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic set_t cur_set();
    return {base, qtd, load, enf, b, a};
  endfunction

  function automatic logic [39:0] rand40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  task automatic cycle();
    if (auto_ack) out_ack = ($urandom_range(0, 2) == 0);
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit ack_with, input int gap_max);
    int n;
    int t;
    bit acc;
    n = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    din_valid = 1'b0;
    repeat (n) cycle();
    din = v;
    din_valid = 1'b1;
    if (ack_with) out_ack = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 300) begin
      acc = din_ready;
      cycle();
      t++;
    end
    din_valid = 1'b0;
    if (ack_with) out_ack = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", v, t);
    end
  endtask

  // Reference: a complete frame yields each field truncated to BW+1 bits.
  task automatic send_frame(input raw_t raw, input bit ack_last, input int gap_max);
    set_t e;
    send_byte(SYNC, 1'b0, gap_max);
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < BPF; k++) begin
        send_byte(raw[f][8*k +: 8], ack_last && (f == 5) && (k == BPF - 1), gap_max);
      end
    end
    for (int f = 0; f < 6; f++) e[f] = raw[f][BW:0];
    exp_q.push_back(e);
  endtask

  task automatic send_junk(input logic [7:0] v);
    send_byte(v, 1'b0, 0);
    exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
  endtask

  task automatic pulse_ack();
    out_ack = 1'b1;
    cycle();
    out_ack = 1'b0;
  endtask

  task automatic do_reset();
    set_t s;
    reset = 1'b1;
    din_valid = 1'b0;
    out_ack = 1'b0;
    exp_q.delete();
    exp_err = 0;
    cycle();
    cycle();
    reset = 1'b0;
    s = cur_set();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_din_ready", 64'(din_ready), 64'd1);
    check("reset_sync_err_cnt", 64'(sync_err_cnt), 64'd0);
    for (int f = 0; f < 6; f++) check($sformatf("reset_field%0d", f), 64'(s[f]), 64'd0);
  endtask

  function automatic raw_t rand_raw();
    raw_t r;
    for (int f = 0; f < 6; f++) r[f] = rand40();
    return r;
  endfunction

  // Monitor: a new set is presented when out_valid is seen after it was low
  // or after the previous set was acknowledged; otherwise the held set must not move.
  always @(negedge sysclk) begin
    set_t cur;
    set_t e;
    if (reset) begin
      prev_valid = 1'b0;
      prev_acked = 1'b0;
    end else begin
      cur = cur_set();
      if (out_valid && (!prev_valid || prev_acked)) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_set: out_valid with no frame outstanding, a=%0h", cur[0]);
        end else begin
          e = exp_q.pop_front();
          for (int f = 0; f < 6; f++) check($sformatf("set_field%0d", f), 64'(cur[f]), 64'(e[f]));
        end
      end else if (out_valid) begin
        check("held_set_stable", 64'(cur != prev_set), 64'd0);
      end else if (prev_valid && !prev_acked) begin
        check("valid_dropped_without_ack", 64'(out_valid), 64'd1);
      end
      prev_valid = out_valid;
      prev_acked = out_valid && out_ack;
      prev_set   = cur;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    raw_t r1;
    raw_t r2;
    logic [7:0] j;

    @(posedge sysclk);
    #1;
    do_reset();

    // Directed frame from the test plan.
    r1[0] = 40'h01_0000_0001;
    r1[1] = 40'h00_DEAD_BEEF;
    r1[2] = 40'h00_0000_0000;
    r1[3] = 40'h01_FFFF_FFFF;
    r1[4] = 40'h00_0000_000F;
    r1[5] = 40'h00_1234_5678;
    send_frame(r1, 1'b0, 0);
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_din_ready", 64'(din_ready), 64'd1);
    cycle();
    pulse_ack();
    check("ack_clears_valid", 64'(out_valid), 64'd0);

    // Junk before a frame, then saturation.
    send_junk(8'h00);
    send_junk(8'h55);
    send_junk(8'hFF);
    send_frame(rand_raw(), 1'b0, 1);
    check("sync_err_three", 64'(sync_err_cnt), 64'(exp_err));
    pulse_ack();
    for (int i = 0; i < 300; i++) begin
      j = 8'($urandom());
      if (j == SYNC) j = 8'h00;
      send_junk(j);
    end
    check("sync_err_saturated", 64'(sync_err_cnt), 64'(exp_err));

    // Back-to-back frames without ack: second waits in the shadow.
    r1 = rand_raw();
    r2 = rand_raw();
    send_frame(r1, 1'b0, 0);
    send_frame(r2, 1'b0, 0);
    check("pend_din_ready", 64'(din_ready), 64'd0);
    cycle();
    cycle();
    check("pend_din_ready_hold", 64'(din_ready), 64'd0);
    check("pend_a_frame1", 64'(a), 64'(r1[0][BW:0]));
    check("pend_base_frame1", 64'(base), 64'(r1[5][BW:0]));
    pulse_ack();
    check("pend_release_valid", 64'(out_valid), 64'd1);
    check("pend_release_din_ready", 64'(din_ready), 64'd1);

    // Ack coinciding with the final byte of the next frame.
    send_frame(rand_raw(), 1'b1, 0);
    check("ack_last_valid", 64'(out_valid), 64'd1);
    check("ack_last_din_ready", 64'(din_ready), 64'd1);

    // Sync value as payload and top-byte masking.
    r1 = rand_raw();
    r1[0] = 40'hFF_1234_5678;
    r1[1] = 40'h00_00AC_0000;
    send_frame(r1, 1'b1, 0);
    check("mask_a_msb", 64'(a[BW]), 64'd1);
    check("payload_sync_in_b", 64'(b[23:16]), 64'hAC);

    // Reset after 17 bytes of a frame.
    pulse_ack();
    r1 = rand_raw();
    send_byte(SYNC, 1'b0, 0);
    for (int i = 0; i < 16; i++) send_byte(r1[i / BPF][8*(i % BPF) +: 8], 1'b0, 0);
    do_reset();
    send_frame(rand_raw(), 1'b0, 0);
    check("post_reset_frame_valid", 64'(out_valid), 64'd1);
    pulse_ack();

    // Randomized traffic with random acks, gaps and junk.
    auto_ack = 1'b1;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) begin
        j = 8'($urandom());
        if (j == SYNC) j = 8'h5A;
        send_junk(j);
      end
      send_frame(rand_raw(), 1'b0, 2);
    end
    auto_ack = 1'b0;
    out_ack = 1'b0;
    cycle();
    for (int i = 0; i < 4 && out_valid; i++) pulse_ack();
    repeat (3) cycle();
    check("random_sync_err", 64'(sync_err_cnt), 64'(exp_err));
    check("final_valid_clear", 64'(out_valid), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_loader.md
# operand_loader

Upstream feeder for the `generic1` operand datapath. Receives a byte stream over a valid/ready handshake and assembles framed operand sets: a sync byte followed by six fields (`a`, `b`, `enf`, `load`, `qtd`, `base`). Each complete set is presented to the datapath as stable, atomically updated registers with a valid/ack pair. A shadow buffer lets the next frame be collected while the current set is still held.

## Interface
Parameters:
- `bus_width`, default 32: operand MSB index; each operand is `bus_width+1` bits.
- `sync_byte`, default 8'b10101100: frame start marker.

Ports:
- `sysclk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  8  stream byte.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  loader accepts `din` this cycle.
- `a`, `b`, `enf`, `load`, `qtd`, `base`  out  `bus_width+1` each  held operand set.
- `out_valid`  out  1  operand set is valid and unacknowledged.
- `out_ack`  in  1  consumer releases the current set.
- `sync_err_cnt`  out  8  count of non-sync bytes discarded while hunting; saturates at 255.

## Operation
- Transfer: a byte transfers on any edge where `din_valid && din_ready`.
- Field size: BPF = (bus_width+8)/8 bytes, sent LSB byte first.
  - Last-byte bits above `bus_width` are ignored.
  - For bus_width=32: BPF=5, frame = 1+30 = 31 bytes.
- Field order: `a`, `b`, `enf`, `load`, `qtd`, `base`.
- State IDLE, `din_ready`=1:
  - Transferred byte == `sync_byte` → LOAD, field and byte counters cleared.
  - Any other byte → discarded, `sync_err_cnt`+1 (saturating).
- State LOAD, `din_ready`=1:
  - Each byte is written into the shadow field at `[8*k +: 8]`.
  - Payload bytes equal to `sync_byte` are ordinary data.
  - On the final byte (field 5, byte BPF-1):
    - If `out_valid`=0 or `out_ack`=1 this cycle: all six outputs load from shadow (including this byte), `out_valid`=1, → IDLE.
    - Otherwise → PEND.
- State PEND, `din_ready`=0:
  - On the edge with `out_ack`=1: outputs load from shadow, `out_valid` stays 1, → IDLE.
- `out_ack` with no new set being loaded clears `out_valid`. `out_ack` while `out_valid`=0 is ignored.
- Outputs never change except by a full six-field load; no partial update is ever visible.

## Timing
- Reset values: all operand outputs 0, `out_valid`=0, `sync_err_cnt`=0, state IDLE (`din_ready`=1), shadow and counters 0.
- Latency: the last byte is accepted at edge N; outputs and `out_valid` change at edge N, visible in the cycle after.
- `din_ready` is decoded from registered state only, with no combinational path from `din_valid` or `out_ack`.
- Ack and completion in the same cycle: new set loads, `out_valid` remains 1, no bubble.
- Reset mid-frame or in PEND: partial or pending frame discarded, everything returns to reset values.
- `din_valid` gaps inside a frame are allowed and have no timeout.

## Structure
- Shared package holds:
  - state enum {IDLE, LOAD, PEND}
  - default `sync_byte` constant
  - field index constants 0..5 and `NUM_FIELDS`=6
  - BPF function of `bus_width`
- Sub-module `field_assembler`: one instance per field. It takes byte index, byte data and write enable, and holds a `bus_width+1` shadow register with upper-bit masking.
- The top level holds the FSM, counters and output registers.

## Test plan
- Reset, then the 31-byte frame AC, a=0x1_0000_0001, b=0x0_DEAD_BEEF, enf=0, load=0x1_FFFF_FFFF, qtd=0xF, base=0x0_1234_5678 → `out_valid`=1 the cycle after the last byte, exact values on outputs, `din_ready`=1.
- Bytes 00, 55, FF, then a frame → `sync_err_cnt`=3 and the frame loads. Then 300 junk bytes → counter holds 255.
- Two back-to-back frames, `out_ack` held 0 → second frame enters PEND, `din_ready`=0, outputs keep frame-1 values. Pulse `out_ack` → frame-2 values appear next edge, `out_valid` stays 1.
- `out_ack` asserted in the same cycle as the last byte of a frame → new values load, `out_valid` never drops.
- Payload byte 0xAC inside the `b` field, plus a last `a` byte of 0xFF → `b` contains 0xAC and `a`[bus_width] = 1 with bits above it discarded.
- `reset` pulsed after 17 bytes of a frame → all outputs 0. A subsequent full frame loads correctly from the sync byte.
